// File: rtl/microwave_timer_controller_pkg.sv
// microwave_timer_controller_pkg: state encodings and BCD limits shared by the timer controller
package microwave_timer_controller_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COOKING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_DONE    = 2'd3
  } state_t;
  localparam logic [3:0] BCD_MAX_SEC_TENS = 4'd5;
  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
endpackage

// File: rtl/microwave_timer_controller_bcd_down_counter3.sv
// bcd_down_counter3: 3-digit M:SS BCD register with shift-in load, clear and borrowing decrement
module bcd_down_counter3
  import microwave_timer_controller_pkg::*;
(
  input  logic       clk,
  input  logic       clearn,
  input  logic       shift,
  input  logic [3:0] digit,
  input  logic       dec,
  input  logic       clr,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic       zero
);
  logic [3:0] so_dec, st_dec, mo_dec;
  always_comb begin
    zero   = (sec_ones == 4'd0) && (sec_tens == 4'd0) && (min_ones == 4'd0);
    so_dec = (sec_ones == 4'd0) ? BCD_MAX_DIGIT : sec_ones - 4'd1;
    st_dec = (sec_ones != 4'd0) ? sec_tens :
             (sec_tens == 4'd0) ? BCD_MAX_SEC_TENS : sec_tens - 4'd1;
    mo_dec = (sec_ones != 4'd0 || sec_tens != 4'd0) ? min_ones : min_ones - 4'd1;
  end
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      sec_ones <= 4'd0;
      sec_tens <= 4'd0;
      min_ones <= 4'd0;
    end else if (clr) begin
      sec_ones <= 4'd0;
      sec_tens <= 4'd0;
      min_ones <= 4'd0;
    end else if (shift) begin
      min_ones <= sec_tens;
      sec_tens <= sec_ones;
      sec_ones <= digit;
    end else if (dec && !zero) begin
      min_ones <= mo_dec;
      sec_tens <= st_dec;
      sec_ones <= so_dec;
    end
  end
endmodule

// File: rtl/microwave_timer_controller.sv
// microwave_timer_controller: keypad-loaded M:SS timer with IDLE/COOKING/PAUSED/DONE cook sequencer
module microwave_timer_controller
  import microwave_timer_controller_pkg::*;
#(
  parameter int DONE_TICKS = 3
) (
  input  logic       clk,
  input  logic       clearn,
  input  logic [3:0] D,
  input  logic       loadn,
  input  logic       p_1hz,
  input  logic       startn,
  input  logic       stopn,
  input  logic       door_closed,
  output logic       enablen,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic       mag_on,
  output logic       done
);
  localparam int CW = $clog2(DONE_TICKS + 1);
  state_t state;
  logic [CW-1:0] done_cnt;
  logic loadn_q, startn_q, stopn_q, p_1hz_q;
  logic key_ev, start_ev, stop_ev, tick, zero, one, shift, dec, clr, start_go;
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      loadn_q  <= 1'b1;
      startn_q <= 1'b1;
      stopn_q  <= 1'b1;
      p_1hz_q  <= 1'b0;
    end else begin
      loadn_q  <= loadn;
      startn_q <= startn;
      stopn_q  <= stopn;
      p_1hz_q  <= p_1hz;
    end
  end
  always_comb begin
    key_ev   = loadn_q & ~loadn;
    start_ev = startn_q & ~startn;
    stop_ev  = stopn_q & ~stopn;
    tick     = ~p_1hz_q & p_1hz;
    one      = (min_ones == 4'd0) && (sec_tens == 4'd0) && (sec_ones == 4'd1);
    start_go = start_ev && door_closed && !zero;
    clr      = stop_ev && (state == ST_IDLE || state == ST_PAUSED);
    shift    = (state == ST_IDLE) && !stop_ev && !start_go && key_ev && (D <= BCD_MAX_DIGIT);
    dec      = (state == ST_COOKING) && door_closed && !stop_ev && tick;
  end
  bcd_down_counter3 u_cnt (
    .clk      (clk),
    .clearn   (clearn),
    .shift    (shift),
    .digit    (D),
    .dec      (dec),
    .clr      (clr),
    .sec_ones (sec_ones),
    .sec_tens (sec_tens),
    .min_ones (min_ones),
    .zero     (zero)
  );
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state    <= ST_IDLE;
      mag_on   <= 1'b0;
      done     <= 1'b0;
      enablen  <= 1'b0;
      done_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: if (!stop_ev && start_go) begin
          state   <= ST_COOKING;
          mag_on  <= 1'b1;
          enablen <= 1'b1;
        end
        ST_COOKING: if (!door_closed || stop_ev) begin
          state  <= ST_PAUSED;
          mag_on <= 1'b0;
        end else if (tick && one) begin
          state    <= ST_DONE;
          mag_on   <= 1'b0;
          done     <= 1'b1;
          done_cnt <= '0;
        end
        ST_PAUSED: if (stop_ev) begin
          state   <= ST_IDLE;
          enablen <= 1'b0;
        end else if (start_ev && door_closed) begin
          state  <= ST_COOKING;
          mag_on <= 1'b1;
        end
        ST_DONE: if (stop_ev || (tick && done_cnt == CW'(DONE_TICKS - 1))) begin
          state   <= ST_IDLE;
          done    <= 1'b0;
          enablen <= 1'b0;
        end else if (tick) begin
          done_cnt <= done_cnt + 1'b1;
        end
        default: begin
          state   <= ST_IDLE;
          mag_on  <= 1'b0;
          done    <= 1'b0;
          enablen <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_microwave_timer_controller.sv
// tb_microwave_timer_controller: directed checks of keypad load, countdown, pause, done and reset
module tb_microwave_timer_controller;
  logic clk = 1'b0;
  logic clearn = 1'b0;
  logic [3:0] D = 4'd0;
  logic loadn = 1'b1, p_1hz = 1'b0, startn = 1'b1, stopn = 1'b1, door_closed = 1'b1;
  logic enablen, mag_on, done;
  logic [3:0] sec_ones, sec_tens, min_ones;
  int n_chk = 0;
  int n_fail = 0;
  microwave_timer_controller #(.DONE_TICKS(3)) dut (
    .clk         (clk),
    .clearn      (clearn),
    .D           (D),
    .loadn       (loadn),
    .p_1hz       (p_1hz),
    .startn      (startn),
    .stopn       (stopn),
    .door_closed (door_closed),
    .enablen     (enablen),
    .sec_ones    (sec_ones),
    .sec_tens    (sec_tens),
    .min_ones    (min_ones),
    .mag_on      (mag_on),
    .done        (done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic key(input logic [3:0] d);
    D = d;
    loadn = 1'b0;
    cyc(3);
    loadn = 1'b1;
    cyc(2);
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      p_1hz = 1'b1;
      cyc(2);
      p_1hz = 1'b0;
      cyc(2);
    end
  endtask
  task automatic start();
    startn = 1'b0;
    cyc(3);
    startn = 1'b1;
    cyc(2);
  endtask
  task automatic stop();
    stopn = 1'b0;
    cyc(3);
    stopn = 1'b1;
    cyc(2);
  endtask
  function automatic logic [31:0] t();
    return {20'd0, min_ones, sec_tens, sec_ones};
  endfunction
  initial begin
    cyc(2);
    check("rst_time", t(), 32'h000);
    check("rst_enablen", enablen, 0);
    check("rst_mag", mag_on, 0);
    check("rst_done", done, 0);
    clearn = 1'b1;
    cyc(2);
    key(4'd1); key(4'd3); key(4'd0);
    check("load_130", t(), 32'h130);
    key(4'hC);
    check("bad_digit", t(), 32'h130);
    start();
    check("cook_mag", mag_on, 1);
    check("cook_enablen", enablen, 1);
    key(4'd7);
    check("cook_key_locked", t(), 32'h130);
    tick(31);
    check("borrow_059", t(), 32'h059);
    tick(58);
    check("at_001", t(), 32'h001);
    check("at_001_mag", mag_on, 1);
    tick(1);
    check("done_flag", done, 1);
    check("done_mag", mag_on, 0);
    check("done_time", t(), 32'h000);
    tick(2);
    check("done_hold", done, 1);
    tick(1);
    check("done_exit", done, 0);
    check("done_exit_en", enablen, 0);
    key(4'd0); key(4'd5);
    check("load_005", t(), 32'h005);
    start();
    tick(2);
    check("pre_door_003", t(), 32'h003);
    door_closed = 1'b0;
    p_1hz = 1'b1;
    cyc(2);
    p_1hz = 1'b0;
    cyc(2);
    check("door_tick_drop", t(), 32'h003);
    check("door_mag", mag_on, 0);
    tick(2);
    check("paused_frozen", t(), 32'h003);
    start();
    check("door_open_start", mag_on, 0);
    door_closed = 1'b1;
    start();
    check("resume_mag", mag_on, 1);
    tick(3);
    check("resume_done", done, 1);
    stop();
    check("done_stop", done, 0);
    check("done_stop_en", enablen, 0);
    key(4'd1); key(4'd0);
    start();
    tick(1);
    stop();
    check("stop_pause_time", t(), 32'h009);
    check("stop_pause_mag", mag_on, 0);
    check("stop_pause_en", enablen, 1);
    tick(1);
    check("stop_pause_frz", t(), 32'h009);
    stop();
    check("stop2_time", t(), 32'h000);
    check("stop2_en", enablen, 0);
    key(4'd2);
    start();
    stop();
    startn = 1'b0;
    stopn = 1'b0;
    cyc(3);
    startn = 1'b1;
    stopn = 1'b1;
    cyc(2);
    check("stop_wins_time", t(), 32'h000);
    check("stop_wins_mag", mag_on, 0);
    check("stop_wins_en", enablen, 0);
    start();
    check("zero_start_mag", mag_on, 0);
    check("zero_start_en", enablen, 0);
    key(4'd7);
    stop();
    check("idle_stop_clr", t(), 32'h000);
    key(4'd9); key(4'd0);
    start();
    tick(1);
    check("tens_gt5", t(), 32'h089);
    stop(); stop();
    key(4'd4);
    start();
    check("pre_rst_mag", mag_on, 1);
    #2 clearn = 1'b0;
    #1;
    check("async_mag", mag_on, 0);
    check("async_time", t(), 32'h000);
    check("async_en", enablen, 0);
    cyc(1);
    clearn = 1'b1;
    cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
